spi_master_engine: RTL and testbench

Single-word SPI master that drives SCLK, SS and MOSI and captures MISO for all four CPOL/CPHA modes. It is the initiating counterpart of the slave-side controller in the SPI interface. It accepts one word per valid/ready handshake, frames it with one SS assertion, and returns the received word as a one-cycle pulse. It sits between the user-side command logic and the off-chip or loopback SPI pins.

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_master_engine_if.sv | 33 +++
 rtl/spi_clk_divider.sv | 37 +++
 rtl/spi_master_engine.sv | 165 ++++++++++++++++
 tb/tb_spi_master_engine.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, mode constants and default sizes.
// Imported by both the master engine and the slave-side controller.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD,
    DONE,
    GAP
  } spi_state_e;

  // Modes encoded as {CPOL, CPHA}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int unsigned SPI_DATA_WIDTH = 8;
  localparam int unsigned SPI_CLK_DIV    = 4;
  localparam int unsigned SPI_SS_GAP     = 2;

  // CPHA=0 samples on leading (odd) edges, CPHA=1 on trailing (even) edges.
  function automatic logic is_sample_edge(input logic cpha, input logic odd_edge);
    return cpha ? ~odd_edge : odd_edge;
  endfunction

endpackage

// File: rtl/spi_master_engine_if.sv
// User-side word handshake of the SPI master engine.
interface spi_master_engine_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  i_tx_valid;
  logic                  o_tx_ready;
  logic [DATA_WIDTH-1:0] o_rx_data;
  logic                  o_rx_valid;
  logic                  o_busy;

  modport master (
    output i_tx_data,
    output i_tx_valid,
    input  o_tx_ready,
    input  o_rx_data,
    input  o_rx_valid,
    input  o_busy
  );

  modport slave (
    input  i_tx_data,
    input  i_tx_valid,
    output o_tx_ready,
    output o_rx_data,
    output o_rx_valid,
    output o_busy
  );

endinterface

// File: rtl/spi_clk_divider.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles plus a parity bit that
// flips on every tick; both restart whenever the divider is cleared or disabled.
module spi_clk_divider #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic enable,
  input  logic clear,
  output logic tick,
  output logic parity
);

  localparam int unsigned CntW = $clog2(CLK_DIV);

  logic [CntW-1:0] cnt_q;
  logic            parity_q;

  assign tick   = enable & ~clear & (cnt_q == CntW'(CLK_DIV - 1));
  assign parity = parity_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q    <= '0;
      parity_q <= 1'b0;
    end else if (clear || !enable) begin
      cnt_q    <= '0;
      parity_q <= 1'b0;
    end else if (tick) begin
      cnt_q    <= '0;
      parity_q <= ~parity_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_engine.sv
// Single-word SPI master supporting all CPOL/CPHA modes; one SS frame per accepted
// word, received word returned with a one-cycle valid pulse.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int unsigned CLK_DIV    = SPI_CLK_DIV,
  parameter int unsigned SS_GAP     = SPI_SS_GAP
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_CPOL,
  input  logic                i_CPHA,
  spi_master_engine_if.slave  bus,
  output logic                o_sclk,
  output logic                o_mosi,
  input  logic                i_miso,
  output logic                o_ss
);

  localparam int unsigned NumEdges = 2 * DATA_WIDTH;
  localparam int unsigned EdgeW    = $clog2(2 * DATA_WIDTH + 1);
  localparam int unsigned GapW     = $clog2(SS_GAP + 1);
  localparam int unsigned GapLast  = (SS_GAP > 1) ? SS_GAP - 2 : 0;

  spi_state_e            state_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] rx_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic [EdgeW-1:0]      edge_q;
  logic [GapW-1:0]       gap_q;
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic                  ss_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  rx_valid_q;

  logic div_en;
  logic div_clr;
  logic div_tick;
  logic div_par;
  logic odd_edge;
  logic last_edge;
  logic sample_edge;
  logic drive_edge;
  logic accept;

  // The divider runs continuously across SETUP/TRANSFER/HOLD; every state change
  // there happens on a tick, where the counter wraps, so each state starts at zero.
  assign div_en  = state_q inside {SETUP, TRANSFER, HOLD};
  assign div_clr = (state_q == IDLE);

  spi_clk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_divider (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .enable  (div_en),
    .clear   (div_clr),
    .tick    (div_tick),
    .parity  (div_par)
  );

  // The SETUP tick is edge 1, so a cleared parity marks an odd (leading) edge.
  assign odd_edge    = ~div_par;
  assign last_edge   = (edge_q == EdgeW'(NumEdges - 1));
  assign sample_edge = is_sample_edge(cpha_q, odd_edge);
  assign drive_edge  = cpha_q ? odd_edge : (~odd_edge & ~last_edge);
  assign accept      = bus.i_tx_valid & ready_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      edge_q     <= '0;
      gap_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          sclk_q <= i_CPOL;
          if (accept) begin
            tx_q    <= bus.i_tx_data;
            cpol_q  <= i_CPOL;
            cpha_q  <= i_CPHA;
            edge_q  <= '0;
            ss_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (!i_CPHA) begin
              mosi_q <= bus.i_tx_data[DATA_WIDTH-1];
            end
            state_q <= SETUP;
          end
        end
        SETUP, TRANSFER: begin
          if (div_tick) begin
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + 1'b1;
            if (sample_edge) begin
              rx_q <= {rx_q[DATA_WIDTH-2:0], i_miso};
            end
            // CPHA=0 already has the MSB on the line, so its shifts expose the next bit.
            if (drive_edge) begin
              mosi_q <= cpha_q ? tx_q[DATA_WIDTH-1] : tx_q[DATA_WIDTH-2];
              tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
            state_q <= last_edge ? HOLD : TRANSFER;
          end
        end
        HOLD: begin
          sclk_q <= cpol_q;
          if (div_tick) begin
            ss_q       <= 1'b1;
            rx_data_q  <= rx_q;
            rx_valid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          gap_q <= '0;
          if (SS_GAP == 1) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= GAP;
          end
        end
        GAP: begin
          if (gap_q == GapW'(GapLast)) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_sclk         = sclk_q;
  assign o_mosi         = mosi_q;
  assign o_ss           = ss_q;
  assign bus.o_tx_ready = ready_q;
  assign bus.o_rx_data  = rx_data_q;
  assign bus.o_rx_valid = rx_valid_q;
  assign bus.o_busy     = busy_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Self-checking bench for spi_master_engine: a behavioural SPI slave and frame
// scoreboard observe the pins each cycle; directed cases plus randomized frames.
module tb_spi_master_engine;

  localparam int unsigned N = 8;
  localparam int unsigned D = 4;
  localparam int unsigned G = 2;

  logic i_clk = 1'b0;
  logic i_reset;
  logic i_CPOL;
  logic i_CPHA;
  logic i_miso;
  logic o_sclk;
  logic o_mosi;
  logic o_ss;

  spi_master_engine_if #(.DATA_WIDTH(N)) bus ();

  spi_master_engine #(
    .DATA_WIDTH (N),
    .CLK_DIV    (D),
    .SS_GAP     (G)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_CPOL  (i_CPOL),
    .i_CPHA  (i_CPHA),
    .bus     (bus),
    .o_sclk  (o_sclk),
    .o_mosi  (o_mosi),
    .i_miso  (i_miso),
    .o_ss    (o_ss)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Scoreboard / slave model state
  bit           in_frame  = 0;
  bit           loop_en   = 0;
  bit           b2b       = 0;
  bit           have_rise = 0;
  bit           accepted  = 0;
  logic [N-1:0] cur_tx, cur_slv, slv_sh, slave_rx, slv_word;
  logic         cur_cpol, cur_cpha, prev_sclk, prev_mosi, miso_slv, mosi_moved;
  int           edge_n, lead_n, acc_cyc, rise_cyc;
  int           nrx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic on_sclk_edge();
    bit odd, samp, drv;
    edge_n++;
    odd = (edge_n % 2) == 1;
    if (o_sclk !== cur_cpol) lead_n++;
    samp = cur_cpha ? !odd : odd;
    drv  = cur_cpha ? odd : (!odd && edge_n != 2 * N);
    if (samp) begin
      check("mosi_stable", o_mosi, prev_mosi);
      slave_rx = {slave_rx[N-2:0], o_mosi};
    end
    if (cur_cpha && edge_n == 1) begin
      check("cpha1_first_mosi", o_mosi, cur_tx[N-1]);
      check("cpha1_no_early_move", mosi_moved, 0);
    end
    if (drv) begin
      miso_slv = slv_sh[N-1];
      slv_sh   = slv_sh << 1;
    end
  endtask

  task automatic step();
    logic acc;
    acc = bus.i_tx_valid && bus.o_tx_ready && i_reset;
    @(posedge i_clk);
    #1;
    cyc++;
    accepted = acc;
    if (acc) begin
      if (b2b && have_rise) check("ss_gap", cyc - rise_cyc, G + 1);
      cur_tx     = bus.i_tx_data;
      cur_cpol   = i_CPOL;
      cur_cpha   = i_CPHA;
      cur_slv    = slv_word;
      slv_sh     = slv_word;
      slave_rx   = '0;
      edge_n     = 0;
      lead_n     = 0;
      mosi_moved = 0;
      in_frame   = 1;
      acc_cyc    = cyc;
      check("acc_ss", o_ss, 0);
      check("acc_ready", bus.o_tx_ready, 0);
      check("acc_busy", bus.o_busy, 1);
      check("setup_sclk", o_sclk, cur_cpol);
      if (!cur_cpha) begin
        check("setup_mosi", o_mosi, cur_tx[N-1]);
        miso_slv = slv_sh[N-1];
        slv_sh   = slv_sh << 1;
      end
      prev_mosi = o_mosi;
    end else if (in_frame) begin
      if (o_sclk !== prev_sclk) on_sclk_edge();
      else if (edge_n == 0 && o_mosi !== prev_mosi) mosi_moved = 1;
      if (bus.o_rx_valid) begin
        check("rx_data", bus.o_rx_data, loop_en ? cur_tx : cur_slv);
        check("slave_rx", slave_rx, cur_tx);
        check("rx_latency", cyc - acc_cyc, (2 * N + 1) * D);
        check("edge_count", edge_n, 2 * N);
        check("leading_edges", lead_n, N);
        check("done_ss", o_ss, 1);
        check("done_sclk", o_sclk, cur_cpol);
        in_frame  = 0;
        rise_cyc  = cyc;
        have_rise = 1;
        nrx++;
      end else begin
        check("frame_ss_low", o_ss, 0);
        check("frame_ready_low", bus.o_tx_ready, 0);
        check("frame_busy", bus.o_busy, 1);
      end
    end else begin
      check("idle_no_rx_valid", bus.o_rx_valid, 0);
      check("idle_ss_high", o_ss, 1);
    end
    prev_sclk = o_sclk;
    prev_mosi = o_mosi;
    i_miso    = loop_en ? o_mosi : miso_slv;
  endtask

  task automatic wait_accept();
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = accepted;
    end
    check("accepted", got, 1);
  endtask

  task automatic do_frame(input logic [N-1:0] data, input logic [1:0] mode, input bit lb,
                          input logic [N-1:0] slv, input bit poke, input bit scramble);
    int start;
    i_CPOL   = mode[1];
    i_CPHA   = mode[0];
    loop_en  = lb;
    slv_word = slv;
    b2b      = 0;
    step();
    step();
    check("idle_sclk_before", o_sclk, i_CPOL);
    bus.i_tx_data  = data;
    bus.i_tx_valid = 1'b1;
    wait_accept();
    bus.i_tx_valid = 1'b0;
    if (scramble) begin
      bus.i_tx_data = N'($urandom);
      i_CPOL        = 1'($urandom_range(0, 1));
      i_CPHA        = 1'($urandom_range(0, 1));
    end
    start = nrx;
    for (int i = 0; i < 400 && nrx == start; i++) begin
      step();
      if (poke && i == 10) begin
        bus.i_tx_data  = N'(8'h55);
        bus.i_tx_valid = 1'b1;
      end
      if (poke && i == 11) bus.i_tx_valid = 1'b0;
    end
    check("frame_done", nrx, start + 1);
    i_CPOL = mode[1];
    for (int i = 0; i < int'(G) + 3; i++) step();
    check("ready_after", bus.o_tx_ready, 1);
    check("busy_after", bus.o_busy, 0);
    check("idle_sclk_after", o_sclk, i_CPOL);
  endtask

  task automatic b2b_test();
    logic [N-1:0] words[3];
    int idx, start;
    words     = '{N'(8'h11), N'(8'h22), N'(8'h33)};
    i_CPOL    = 1'b0;
    i_CPHA    = 1'b0;
    loop_en   = 1;
    step();
    step();
    b2b       = 1;
    have_rise = 0;
    idx       = 0;
    start     = nrx;
    bus.i_tx_data  = words[0];
    bus.i_tx_valid = 1'b1;
    for (int i = 0; i < 600 && nrx < start + 3; i++) begin
      step();
      if (accepted) begin
        idx++;
        if (idx < 3) bus.i_tx_data = words[idx];
        else bus.i_tx_valid = 1'b0;
      end
    end
    bus.i_tx_valid = 1'b0;
    check("b2b_frames", nrx - start, 3);
    b2b = 0;
  endtask

  task automatic reset_test();
    int start;
    i_CPOL   = 1'b0;
    i_CPHA   = 1'b0;
    loop_en  = 1;
    step();
    start = nrx;
    bus.i_tx_data  = N'(8'hF0);
    bus.i_tx_valid = 1'b1;
    wait_accept();
    bus.i_tx_valid = 1'b0;
    for (int i = 0; i < 200 && edge_n < 5; i++) step();
    check("reached_edge5", edge_n, 5);
    i_reset = 1'b0;
    #1;
    check("rst_ss", o_ss, 1);
    check("rst_sclk", o_sclk, 0);
    check("rst_mosi", o_mosi, 0);
    check("rst_rx_valid", bus.o_rx_valid, 0);
    check("rst_ready", bus.o_tx_ready, 1);
    check("rst_busy", bus.o_busy, 0);
    check("rst_rx_data", bus.o_rx_data, 0);
    in_frame = 0;
    for (int i = 0; i < 3; i++) step();
    i_reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("rst_no_frame", nrx, start);
    do_frame(N'(8'h0F), spi_pkg::SPI_MODE0, 1, '0, 0, 0);
  endtask

  initial begin
    i_reset        = 1'b0;
    i_CPOL         = 1'b0;
    i_CPHA         = 1'b0;
    i_miso         = 1'b0;
    miso_slv       = 1'b0;
    slv_word       = '0;
    bus.i_tx_data  = '0;
    bus.i_tx_valid = 1'b0;
    #12;
    check("reset_ss", o_ss, 1);
    check("reset_sclk", o_sclk, 0);
    check("reset_mosi", o_mosi, 0);
    check("reset_ready", bus.o_tx_ready, 1);
    check("reset_busy", bus.o_busy, 0);
    check("reset_rx_valid", bus.o_rx_valid, 0);
    check("reset_rx_data", bus.o_rx_data, 0);
    i_reset   = 1'b1;
    prev_sclk = o_sclk;
    prev_mosi = o_mosi;
    step();

    do_frame(N'(8'hA5), spi_pkg::SPI_MODE0, 1, '0, 0, 0);
    do_frame(N'(8'hC3), spi_pkg::SPI_MODE3, 0, N'(8'h3C), 0, 0);
    do_frame(N'(8'h81), spi_pkg::SPI_MODE1, 1, '0, 0, 0);
    do_frame(N'(8'h7E), spi_pkg::SPI_MODE2, 1, '0, 0, 0);
    b2b_test();
    reset_test();
    do_frame(N'(8'h96), spi_pkg::SPI_MODE1, 0, N'(8'h5A), 1, 0);

    for (int i = 0; i < 12; i++) begin
      do_frame(N'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               N'($urandom), 1'($urandom_range(0, 1)), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
